// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the FIFO control stage in front of the 256x9 storage block.
package fifo_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH    = 256;
    localparam int unsigned FIFO_CNT_W    = 9;
    localparam int unsigned FIFO_AF_LEVEL = 240;
    localparam int unsigned FIFO_AE_LEVEL = 16;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH
    } state_e;

    typedef enum logic {
        GRANT_WRITE,
        GRANT_READ
    } grant_e;

endpackage

// File: rtl/fifo_occ_counter.sv
// Occupancy counter with synchronous clear and full/empty/almost flag decode of the registered count.
module fifo_occ_counter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = FIFO_DEPTH,
    parameter int unsigned CNT_W    = FIFO_CNT_W,
    parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL,
    parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // inc and dec are never both asserted; the arbiter guarantees it.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o        = count_q;
    assign full_o         = (count_q == CNT_W'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty_o = (count_q <= CNT_W'(AE_LEVEL));

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: arbitrates push/pop into mutually exclusive storage strobes, tracks occupancy and errors.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = FIFO_DEPTH,
    parameter int unsigned CNT_W    = FIFO_CNT_W,
    parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL,
    parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push_req,
    output logic             push_ack,
    input  logic             pop_req,
    output logic             pop_ack,
    output logic             wren,
    output logic             rden,
    output logic             wr_inc,
    output logic             rd_inc,
    output logic             wr_ptr_clr,
    output logic             rd_ptr_clr,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             ovf_err,
    output logic             udf_err
);

    state_e state_q;
    grant_e last_grant_q;
    logic   rd_valid_q;
    logic   ovf_err_q;
    logic   udf_err_q;
    logic   wr_gnt;
    logic   rd_gnt;
    logic   can_w;
    logic   can_r;

    fifo_occ_counter #(
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_occ (
        .clk_i          (clk),
        .rst_ni         (rst),
        .clr_i          (state_q == FLUSH),
        .inc_i          (wr_gnt),
        .dec_i          (rd_gnt),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty)
    );

    // Contended cycles go to the opposite of the last grant, so mixed traffic alternates W/R.
    always_comb begin
        can_w  = push_req & ~full;
        can_r  = pop_req & ~empty;
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (state_q == RUN) begin
            if (can_w && can_r) begin
                if (last_grant_q == GRANT_READ) begin
                    wr_gnt = 1'b1;
                end else begin
                    rd_gnt = 1'b1;
                end
            end else begin
                wr_gnt = can_w;
                rd_gnt = can_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            last_grant_q <= GRANT_READ;
            rd_valid_q   <= 1'b0;
            ovf_err_q    <= 1'b0;
            udf_err_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    state_q    <= RUN;
                    rd_valid_q <= 1'b0;
                end
                RUN: begin
                    if (clr) begin
                        state_q <= FLUSH;
                    end
                    if (wr_gnt) begin
                        last_grant_q <= GRANT_WRITE;
                    end else if (rd_gnt) begin
                        last_grant_q <= GRANT_READ;
                    end
                    rd_valid_q <= rd_gnt;
                    if (push_req && full) begin
                        ovf_err_q <= 1'b1;
                    end
                    if (pop_req && empty) begin
                        udf_err_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    state_q    <= RUN;
                    rd_valid_q <= 1'b0;
                    ovf_err_q  <= 1'b0;
                    udf_err_q  <= 1'b0;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    // Pointer clears are gated by rst so they stay low while reset is held and INIT fires on the first clock after release.
    assign wr_ptr_clr = rst & (state_q != RUN);
    assign rd_ptr_clr = rst & (state_q != RUN);

    assign push_ack = wr_gnt;
    assign pop_ack  = rd_gnt;
    assign wren     = wr_gnt;
    assign wr_inc   = wr_gnt;
    assign rden     = rd_gnt;
    assign rd_inc   = rd_gnt;
    assign rd_valid = rd_valid_q;
    assign ovf_err  = ovf_err_q;
    assign udf_err  = udf_err_q;

endmodule
